// File: rtl/outpass_pkg.sv
// outpass_pkg: shared helpers for the parametrised output-pass BEL.
// Provides the width derivation for the per-channel tap field, the tap-index
// type and the clamp used when a tap code exceeds the chain length.
package outpass_pkg;

  // Wide enough for any tap code a realistic MAX_DEPTH can produce.
  localparam int TAP_IDX_W = 8;

  typedef logic [TAP_IDX_W-1:0] tapIdx_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Floor log2 for value >= 1; used to find a mux-tree node's level.
  function automatic int floorLog2(input int value);
    int result;
    result = 0;
    while ((2 << result) <= value) result++;
    return result;
  endfunction

  // Config bits per channel: enough to encode 0 (bypass) .. maxDepth.
  function automatic int depthWidth(input int maxDepth);
    return clog2(maxDepth + 1);
  endfunction

  // Tap codes beyond the chain end select the last stage.
  function automatic tapIdx_t clampTap(input tapIdx_t tap, input int maxDepth);
    return (int'(tap) > maxDepth) ? tapIdx_t'(maxDepth) : tap;
  endfunction

endpackage

// File: rtl/my_mux2.sv
// my_mux2: fabric 2:1 mux primitive used to build the tap-select trees.
module my_mux2 (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/outpass_delay_line.sv
// outpass_delay_line: one output-pass channel.
// A MAX_DEPTH-stage shift chain always records the input history; a binary
// tree of my_mux2 cells selects either the raw input (tap 0) or chain stage
// tap. Tap codes above MAX_DEPTH are wired to the last stage, so the tree
// itself performs the clamp. The output is never re-registered: for tap >= 1
// it comes straight from a flop Q through the mux, for tap 0 it is purely
// combinational.
module outpass_delay_line import outpass_pkg::*; #(
  parameter  int MAX_DEPTH = 3,
  localparam int DEPTH_W   = depthWidth(MAX_DEPTH)
) (
  input  logic               UserCLK,
  input  logic               UserRST,
  input  logic               chainEn,
  input  logic               I,
  input  logic [DEPTH_W-1:0] tap,
  output logic               O
);

  localparam int LEAVES = 1 << DEPTH_W;

  // chain[k] holds the input sampled k enabled edges ago.
  logic [MAX_DEPTH:1]    chain;
  // Heap-indexed mux tree: node[1] is the root, node[LEAVES + t] is leaf t.
  logic [2*LEAVES-1:1]   node;

  // Shift chain: advance on every enabled edge, clear on reset (reset wins).
  always_ff @(posedge UserCLK) begin
    // NOTE: the chain must be reset, because with tap >= 1 the output is
    // defined to read 0 until real post-reset samples reach that stage.
    if (UserRST) begin
      chain <= '0;
    end else if (chainEn) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, so the loop order does not matter and nothing collapses.
      chain[1] <= I;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  // Leaves: code 0 is the bypass, the rest map (clamped) onto chain stages.
  for (genvar t = 0; t < LEAVES; t++) begin : g_leaf
    if (t == 0) begin : g_bypass
      assign node[LEAVES] = I;
    end else begin : g_tap
      localparam int SRC = int'(clampTap(tapIdx_t'(t), MAX_DEPTH));
      assign node[LEAVES + t] = chain[SRC];
    end
  end

  // Internal nodes: the root decodes the tap MSB, leaf parents the LSB.
  for (genvar n = 1; n < LEAVES; n++) begin : g_mux
    localparam int SEL_BIT = DEPTH_W - 1 - floorLog2(n);
    my_mux2 u_mux (
      .A0 (node[2*n]),
      .A1 (node[2*n + 1]),
      .S  (tap[SEL_BIT]),
      .X  (node[n])
    );
  end

  assign O = node[1];

endmodule

// File: rtl/outpass_n_frame_config.sv
// outpass_n_frame_config: NUM_CH-channel tile output pass.
// Each channel drives its switch-matrix input to the tile edge either
// combinationally or delayed by 1..MAX_DEPTH UserCLK cycles, as chosen by
// its slice of the frame configuration bits.
// Build option: define OUTPASS_CE_EN to add the CE port, a common clock
// enable that freezes every shift chain while low (bypass channels and
// reset are unaffected).
module outpass_n_frame_config import outpass_pkg::*; #(
  parameter  int NUM_CH       = 4,
  parameter  int MAX_DEPTH    = 3,
  localparam int DEPTH_W      = depthWidth(MAX_DEPTH),
  localparam int NoConfigBits = NUM_CH * DEPTH_W
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
`ifdef OUTPASS_CE_EN
  input  logic                    CE,
`endif
  input  logic [NUM_CH-1:0]       I,
  output logic [NUM_CH-1:0]       O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  logic chainEn;

`ifdef OUTPASS_CE_EN
  assign chainEn = CE;
`else
  assign chainEn = 1'b1;
`endif

  // One independent delay line per channel, each with its own tap field.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    outpass_delay_line #(
      .MAX_DEPTH (MAX_DEPTH)
    ) u_line (
      .UserCLK (UserCLK),
      .UserRST (UserRST),
      .chainEn (chainEn),
      .I       (I[c]),
      .tap     (ConfigBits[c*DEPTH_W +: DEPTH_W]),
      .O       (O[c])
    );
  end

endmodule

// File: tb/tb_outpass_n_frame_config.sv
// Testbench for outpass_n_frame_config: a default 4-channel, depth-3 instance
// plus a 2-channel, depth-2 instance for tap clamping. Expected outputs are
// queued when stimulus is applied and popped after each clock edge.
module tb_outpass_n_frame_config;

  logic       UserCLK;
  logic       UserRST;
  logic [3:0] I;
  logic [3:0] O;
  logic [7:0] ConfigBits;

  logic [1:0] clampI;
  logic [1:0] clampO;
  logic [3:0] clampCfg;

`ifdef OUTPASS_CE_EN
  logic CE;
`endif

  int checks;
  int errors;

  logic [3:0] expQ[$];
  logic [1:0] clampQ[$];

  outpass_n_frame_config #(
    .NUM_CH    (4),
    .MAX_DEPTH (3)
  ) dut (
    .UserCLK    (UserCLK),
    .UserRST    (UserRST),
`ifdef OUTPASS_CE_EN
    .CE         (CE),
`endif
    .I          (I),
    .O          (O),
    .ConfigBits (ConfigBits)
  );

  outpass_n_frame_config #(
    .NUM_CH    (2),
    .MAX_DEPTH (2)
  ) dutClamp (
    .UserCLK    (UserCLK),
    .UserRST    (UserRST),
`ifdef OUTPASS_CE_EN
    .CE         (CE),
`endif
    .I          (clampI),
    .O          (clampO),
    .ConfigBits (clampCfg)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  // Hard stop in case anything stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Step one rising edge, then return 1 time unit later to drive/sample.
  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic applyReset();
    UserRST = 1'b1;
    tick();
    UserRST = 1'b0;
  endtask

  // T = {3,2,1,0} for channels 3..0, all inputs high.
  task automatic test_reset();
    logic [3:0] relExp[3];
    relExp = '{4'b0011, 4'b0111, 4'b1111};
    ConfigBits = {2'd3, 2'd2, 2'd1, 2'd0};
    I          = 4'b1111;
    clampCfg   = {2'd3, 2'd3};
    clampI     = 2'b11;
    UserRST    = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (O !== 4'b0001) begin
        errors++;
        $display("FAIL reset cycle %0d: O=%b expected %b", n, O, 4'b0001);
      end
    end
    checks++;
    if (clampO !== 2'b00) begin
      errors++;
      $display("FAIL reset clamp instance: O=%b expected %b", clampO, 2'b00);
    end
    UserRST = 1'b0;
    #1;
    checks++;
    if (O !== 4'b0001) begin
      errors++;
      $display("FAIL reset release before edge: O=%b expected %b", O, 4'b0001);
    end
    // Tap T shows post-reset data T edges after release.
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (O !== relExp[n]) begin
        errors++;
        $display("FAIL reset release edge %0d: O=%b expected %b", n + 1, O, relExp[n]);
      end
    end
  endtask

  // Uniform taps 1..3: walking one followed by random words.
  task automatic test_latency();
    logic [3:0] expVal;
    for (int tap = 1; tap <= 3; tap++) begin
      ConfigBits = {4{2'(tap)}};
      applyReset();
      expQ.delete();
      for (int k = 1; k < tap; k++) expQ.push_back(4'b0000);
      for (int n = 0; n < 8; n++) begin
        I = (n < 4) ? (4'b0001 << n) : 4'($urandom);
        expQ.push_back(I);
        tick();
        expVal = expQ.pop_front();
        checks++;
        if (O !== expVal) begin
          errors++;
          $display("FAIL latency tap=%0d step=%0d: O=%b expected %b", tap, n, O, expVal);
        end
      end
    end
  endtask

  // Tap 0 follows I without any clock edge.
  task automatic test_bypass();
    logic [3:0] pattern[6];
    pattern = '{4'b0000, 4'b1111, 4'b1010, 4'b0101, 4'b0001, 4'b1000};
    ConfigBits = 8'h00;
    tick();
    for (int n = 0; n < 6; n++) begin
      I = pattern[n];
      #1;
      checks++;
      if (O !== pattern[n]) begin
        errors++;
        $display("FAIL bypass all-T0 step=%0d: O=%b expected %b", n, O, pattern[n]);
      end
    end
    // Channel 0 bypassed, the others registered: only bit 0 moves mid-cycle.
    ConfigBits = {2'd1, 2'd1, 2'd1, 2'd0};
    I = 4'b0000;
    tick();
    I = 4'b0001;
    #1;
    checks++;
    if (O !== 4'b0001) begin
      errors++;
      $display("FAIL bypass mixed rise: O=%b expected %b", O, 4'b0001);
    end
    I = 4'b1110;
    #1;
    checks++;
    if (O !== 4'b0000) begin
      errors++;
      $display("FAIL bypass mixed fall: O=%b expected %b", O, 4'b0000);
    end
  endtask

  // Ones for 5 edges then zero; retune 3 -> 1 (and 2) after the drop.
  task automatic test_live_reconfig();
    logic [3:0] expVal;
    ConfigBits = 8'hFF;
    applyReset();
    expQ.delete();
    expQ.push_back(4'b0000);
    expQ.push_back(4'b0000);
    for (int n = 0; n < 6; n++) begin
      I = (n < 5) ? 4'b1111 : 4'b0000;
      expQ.push_back(I);
      tick();
      expVal = expQ.pop_front();
      checks++;
      if (O !== expVal) begin
        errors++;
        $display("FAIL live stream step=%0d: O=%b expected %b", n, O, expVal);
      end
    end
    ConfigBits = 8'h55;
    #1;
    checks++;
    if (O !== 4'b0000) begin
      errors++;
      $display("FAIL live switch to T1: O=%b expected %b", O, 4'b0000);
    end
    ConfigBits = 8'hAA;
    #1;
    checks++;
    if (O !== 4'b1111) begin
      errors++;
      $display("FAIL live switch to T2: O=%b expected %b", O, 4'b1111);
    end
  endtask

  // Depth-2 instance: tap code 3 on channel 0 must match tap 2 on channel 1.
  task automatic test_clamp();
    logic [1:0] expVal;
    logic       bitVal;
    clampCfg = {2'd2, 2'd3};
    applyReset();
    clampQ.delete();
    clampQ.push_back(2'b00);
    for (int n = 0; n < 10; n++) begin
      bitVal = (n < 4) ? ((n % 2) == 0) : 1'($urandom);
      clampI = {bitVal, bitVal};
      clampQ.push_back(clampI);
      tick();
      expVal = clampQ.pop_front();
      checks++;
      if (clampO !== expVal) begin
        errors++;
        $display("FAIL clamp step=%0d: O=%b expected %b", n, clampO, expVal);
      end
    end
  endtask

`ifdef OUTPASS_CE_EN
  // Freeze chains for 3 edges, resume without loss, reset while frozen.
  task automatic test_ce();
    logic [3:0] expVal;
    logic [3:0] stim[5];
    stim = '{4'b0101, 4'b1010, 4'b0011, 4'b1100, 4'b1001};
    CE = 1'b1;
    ConfigBits = 8'hAA;
    applyReset();
    expQ.delete();
    expQ.push_back(4'b0000);
    for (int n = 0; n < 5; n++) begin
      if (n == 2) begin
        CE = 1'b0;
        for (int h = 0; h < 3; h++) begin
          I = 4'($urandom);
          tick();
          checks++;
          if (O !== 4'b0101) begin
            errors++;
            $display("FAIL ce hold %0d: O=%b expected %b", h, O, 4'b0101);
          end
        end
        CE = 1'b1;
      end
      I = stim[n];
      expQ.push_back(I);
      tick();
      expVal = expQ.pop_front();
      checks++;
      if (O !== expVal) begin
        errors++;
        $display("FAIL ce stream step=%0d: O=%b expected %b", n, O, expVal);
      end
    end
    CE = 1'b0;
    ConfigBits = 8'h00;
    I = 4'b0110;
    #1;
    checks++;
    if (O !== 4'b0110) begin
      errors++;
      $display("FAIL ce bypass while frozen: O=%b expected %b", O, 4'b0110);
    end
    ConfigBits = 8'hAA;
    UserRST = 1'b1;
    tick();
    UserRST = 1'b0;
    checks++;
    if (O !== 4'b0000) begin
      errors++;
      $display("FAIL ce reset while frozen T2: O=%b expected %b", O, 4'b0000);
    end
    ConfigBits = 8'h55;
    #1;
    checks++;
    if (O !== 4'b0000) begin
      errors++;
      $display("FAIL ce reset while frozen T1: O=%b expected %b", O, 4'b0000);
    end
    CE = 1'b1;
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    UserRST    = 1'b1;
    I          = 4'b0000;
    ConfigBits = 8'h00;
    clampI     = 2'b00;
    clampCfg   = 4'h0;
`ifdef OUTPASS_CE_EN
    CE         = 1'b1;
`endif

    test_reset();
    test_latency();
    test_bypass();
    test_live_reconfig();
    test_clamp();
`ifdef OUTPASS_CE_EN
    test_ce();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/outpass_n_frame_config.md
# outpass_n_frame_config

Parametrised tile output-pass BEL for the fabric. It takes NUM_CH switch-matrix signals and drives them to the tile boundary (EXTERNAL). Each channel independently selects either combinational pass-through or a delay of 1..MAX_DEPTH UserCLK cycles, taken from a per-channel shift chain. Selection is set by frame configuration bits. It supersedes the fixed 4-channel, single-flop output pass.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels.
- MAX_DEPTH, 3: longest selectable delay in cycles; minimum 1.
- DEPTH_W (localparam): clog2(MAX_DEPTH+1); config bits per channel.
- NoConfigBits (localparam): NUM_CH*DEPTH_W; with defaults, 8.

Ports:
- UserCLK  in  1  fabric user clock; all state on rising edge. EXTERNAL, SHARED_PORT.
- UserRST  in  1  synchronous, active-high reset.
- I  in  NUM_CH  channel inputs from the switch matrix.
- O  out  NUM_CH  channel outputs, EXTERNAL.
- ConfigBits  in  NoConfigBits  per-channel delay select. Channel c uses ConfigBits[c*DEPTH_W +: DEPTH_W] (tap value T_c).
- CE  in  1  chain clock-enable. Present only with OUTPASS_CE_EN.

## Operation
- Per channel c, shift chain S_c[1..MAX_DEPTH], updated every UserCLK edge with CE asserted or compiled out:
  - S_c[1] <= I[c]
  - S_c[k] <= S_c[k-1] for k = 2..MAX_DEPTH
- Output select:
  - T_c = 0: O[c] = I[c], purely combinational; no flop in the path.
  - 1 <= T_c <= MAX_DEPTH: O[c] = S_c[T_c].
  - T_c > MAX_DEPTH (possible when MAX_DEPTH+1 is not a power of 2): clamp to S_c[MAX_DEPTH].
- Output mux is a combinational function of ConfigBits. A ConfigBits change takes effect on O in the same cycle, with no flush and no glitch suppression.
- Chains always run regardless of T_c, so every tap always holds valid history.
- Channels are fully independent; there is no cross-channel state.
- Reset, with UserRST high at an edge:
  - All S_c[k] <= 0. UserRST has priority over CE.
  - Reset output values: O[c] = I[c] for T_c = 0; O[c] = 0 for T_c >= 1.
- Reset mid-stream: in-flight samples are discarded. A channel with tap T first shows post-reset input T edges after UserRST falls and shows 0 until then.

## Timing
- T = 0: zero latency, combinational I -> O.
- T = k: O at cycle n+k equals I sampled at edge n. Throughput is one sample per cycle.
- ConfigBits -> O is combinational. ConfigBits is static in normal use (frame config).
- No handshakes. Output is registered only when T >= 1, and then it is driven directly from a flop Q through the mux.

## Configuration
- OUTPASS_CE_EN defined:
  - Adds port CE.
  - CE = 0 freezes all chains; O for T >= 1 holds its value.
  - T = 0 channels are unaffected by CE.
  - UserRST still clears the chains while CE = 0.
- OUTPASS_CE_EN undefined:
  - No CE port.
  - Chains advance every edge.

## Structure
- Package outpass_pkg holds:
  - clog2 function and DEPTH_W derivation.
  - Tap-index type.
  - Clamp helper for the tap value.
- Sub-module outpass_delay_line: one channel, consisting of the shift chain plus tap mux built from my_mux2 trees. The top level instantiates it NUM_CH times in a generate loop and slices ConfigBits.

## Test plan
- Reset check: UserRST=1 for 2 cycles with I=4'b1111 and T={0,1,2,3}. Required during reset: O=4'b0001. Then release UserRST.
- Latency: all T=2, with I driven as a walking-one 0001, 0010, 0100, 1000 on consecutive edges. Required: O shows the same pattern delayed exactly 2 edges.
- Bypass: T_c=0, toggle I[c] between edges. Required: O[c] follows in the same cycle with no clock involved.
- Live reconfig: with I=1 held for 5 cycles and then 0, switch T from 3 to 1 on the cycle after the drop. Required: O changes immediately to S[1]=0.
- Clamp: MAX_DEPTH=2 (DEPTH_W=2), T=3. Required: behaves as T=2.
- CE (OUTPASS_CE_EN only): CE=0 for 3 cycles while I toggles. Required: T>=1 outputs hold; after CE=1 the chain resumes with no lost or duplicated sample. UserRST with CE=0 still zeroes O.
